rf_dump_reader: RTL and testbench

- Debug/verification reader for the core's register file: sweeps an index range over one register-file read port and streams each register value out over a valid/ready interface.
- Sits beside the register file, sharing a read port address mux with the decode stage.
- Holds the core via core_stall for the whole dump, so the streamed values are a consistent architectural snapshot.

---
 rtl/rf_dump_reader_pkg.sv | 15 +
 rtl/rf_dump_reader.sv | 115 +++++++++++
 tb/tb_rf_dump_reader.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_reader_pkg.sv
// Shared core constants and the dump-reader state encoding.
package rf_dump_reader_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int XLEN          = 32;
    localparam int NUM_ARCH_REGS = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/rf_dump_reader.sv
// Register-file dump reader: sweeps [first_idx, last_idx] over one RF read
// port and streams each value out on a valid/ready interface. The core is
// held via core_stall for the whole dump so the values form a consistent
// architectural snapshot.
module rf_dump_reader
    import rf_dump_reader_pkg::*;
#(
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              core_stall,
    output logic              done
);

    // One extra bit so NUM_REGS == 2**ADDR_W is representable in comparisons.
    localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] MAX_IDX    = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state;
    dump_state_t       next_state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_r;
    logic              empty_range;
    logic [ADDR_W-1:0] last_clamped;

    // A reversed range or a first index past the register file yields zero beats.
    assign empty_range  = (first_idx > last_idx) || ({1'b0, first_idx} >= NUM_REGS_X);
    assign last_clamped = ({1'b0, last_idx} >= NUM_REGS_X) ? MAX_IDX : last_idx;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        // NOTE: default first, so no path through the case leaves next_state
        // unassigned and infers a latch.
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = empty_range ? DONE : READ;
                end
            end
            READ: next_state = SEND;
            SEND: begin
                if (out_ready) begin
                    next_state = out_last ? DONE : READ;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Index counter and output beat registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            last_r    <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx    <= first_idx;
                        last_r <= last_clamped;
                    end
                end
                READ: begin
                    out_data  <= rf_data;
                    out_index <= idx;
                    out_last  <= (idx == last_r) || (idx == MAX_IDX);
                end
                SEND: begin
                    if (out_ready && !out_last) begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The read address follows idx in every state, so it only moves when idx does.
    assign rf_addr    = idx;
    assign out_valid  = (state == SEND);
    assign busy       = (state != IDLE);
    assign core_stall = busy;
    assign done       = (state == DONE);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: a 32-entry DUT on a modelled register
// file plus a 31-entry instance for the clamped-range case.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rst;

    // Main instance (NUM_REGS = 32).
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        core_stall;
    logic        done;

    // Second instance (NUM_REGS = 31).
    logic        start2;
    logic [4:0]  first2;
    logic [4:0]  last2;
    logic [4:0]  rf_addr2;
    logic [31:0] rf_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] out_data2;
    logic [4:0]  out_index2;
    logic        out_last2;
    logic        busy2;
    logic        core_stall2;
    logic        done2;

    logic [31:0] rf [32];

    int n_cmp = 0;
    int n_bad = 0;

    // Captured beats of the most recent dump.
    int          beat_idx[$];
    logic [31:0] beat_dat[$];
    logic        beat_last[$];
    int          done_cyc;
    int          first_valid_cyc;
    logic        busy_after;
    int          stall_bad;

    always #5 clk = ~clk;

    assign rf_data  = rf[rf_addr];
    assign rf_data2 = 32'hA000 + {27'd0, rf_addr2};

    rf_dump_reader u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_idx  (first_idx),
        .last_idx   (last_idx),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .core_stall (core_stall),
        .done       (done)
    );

    rf_dump_reader #(.NUM_REGS(31)) u_dut31 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .first_idx  (first2),
        .last_idx   (last2),
        .rf_addr    (rf_addr2),
        .rf_data    (rf_data2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .out_data   (out_data2),
        .out_index  (out_index2),
        .out_last   (out_last2),
        .busy       (busy2),
        .core_stall (core_stall2),
        .done       (done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle; that cycle counts as cycle 1 of the dump.
    task automatic do_start(input logic [4:0] f, input logic [4:0] l);
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Collect beats from cycle 2 onward until done, then look one cycle past it.
    task automatic capture(input int budget);
        beat_idx.delete();
        beat_dat.delete();
        beat_last.delete();
        done_cyc        = 0;
        first_valid_cyc = 0;
        stall_bad       = 0;
        busy_after      = 1'bx;
        for (int c = 2; c <= budget; c++) begin
            if (core_stall !== busy) stall_bad++;
            if (out_valid && first_valid_cyc == 0) first_valid_cyc = c;
            if (out_valid && out_ready) begin
                beat_idx.push_back(int'(out_index));
                beat_dat.push_back(out_data);
                beat_last.push_back(out_last);
            end
            if (done) begin
                done_cyc = c;
                step();
                busy_after = busy;
                return;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 | i;
        rf[0]  = 32'h0;
        rf[6]  = 32'h6;
        rf[7]  = 32'h9;
        rf[8]  = 32'h8;
        rf[9]  = 32'h20;
        rf[12] = 32'h1;
        rf[13] = 32'h2;

        rst        = 1'b0;
        start      = 1'b0;
        first_idx  = '0;
        last_idx   = '0;
        out_ready  = 1'b1;
        start2     = 1'b0;
        first2     = '0;
        last2      = '0;
        out_ready2 = 1'b1;

        // Reset values.
        #2;
        check("rst_out_valid",  out_valid,  1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_core_stall", core_stall, 1'b0);
        check("rst_done",       done,       1'b0);
        check("rst_out_last",   out_last,   1'b0);
        check("rst_rf_addr",    rf_addr,    5'd0);
        check("rst_out_data",   out_data,   32'd0);
        check("rst_out_index",  out_index,  5'd0);
        #10 rst = 1'b1;
        step();

        // Dump 6..9 with out_ready high.
        do_start(5'd6, 5'd9);
        capture(100);
        check("d69_timeout",  done_cyc != 0, 1'b1);
        check("d69_beats",    beat_idx.size(), 4);
        if (beat_idx.size() == 4) begin
            check("d69_idx0", beat_idx[0], 6);  check("d69_dat0", beat_dat[0], 32'h6);
            check("d69_idx1", beat_idx[1], 7);  check("d69_dat1", beat_dat[1], 32'h9);
            check("d69_idx2", beat_idx[2], 8);  check("d69_dat2", beat_dat[2], 32'h8);
            check("d69_idx3", beat_idx[3], 9);  check("d69_dat3", beat_dat[3], 32'h20);
            check("d69_last0", beat_last[0], 1'b0);
            check("d69_last1", beat_last[1], 1'b0);
            check("d69_last2", beat_last[2], 1'b0);
            check("d69_last3", beat_last[3], 1'b1);
        end
        check("d69_first_valid_cyc", first_valid_cyc, 3);
        check("d69_done_cyc",        done_cyc,        10);
        check("d69_busy_after_done", busy_after,      1'b0);
        check("d69_stall_eq_busy",   stall_bad,       0);
        check("d69_done_pulse",      done,            1'b0);

        // Full dump 0..31.
        do_start(5'd0, 5'd31);
        capture(200);
        check("full_timeout", done_cyc != 0, 1'b1);
        check("full_beats",   beat_idx.size(), 32);
        if (beat_idx.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                check($sformatf("full_idx%0d", i),  beat_idx[i],  i);
                check($sformatf("full_dat%0d", i),  beat_dat[i],  rf[i]);
                check($sformatf("full_last%0d", i), beat_last[i], (i == 31));
            end
            check("full_x0",  beat_dat[0],  32'h0);
            check("full_x12", beat_dat[12], 32'h1);
            check("full_x13", beat_dat[13], 32'h2);
        end
        check("full_done_cyc", done_cyc, 66);

        // Backpressure: dump 12..13, beat 12 stalled for 5 cycles.
        out_ready = 1'b0;
        do_start(5'd12, 5'd13);
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_valid_%0d", k), out_valid, 1'b1);
            check($sformatf("bp_data_%0d", k),  out_data,  32'h1);
            check($sformatf("bp_index_%0d", k), out_index, 5'd12);
            check($sformatf("bp_last_%0d", k),  out_last,  1'b0);
            step();
        end
        out_ready = 1'b1;
        check("bp_valid_release", out_valid, 1'b1);
        check("bp_data_release",  out_data,  32'h1);
        step();
        check("bp_valid_drop",  out_valid, 1'b0);
        step();
        check("bp_b13_valid",   out_valid, 1'b1);
        check("bp_b13_index",   out_index, 5'd13);
        check("bp_b13_data",    out_data,  32'h2);
        check("bp_b13_last",    out_last,  1'b1);
        step();
        check("bp_done",        done,      1'b1);
        check("bp_no_extra",    out_valid, 1'b0);
        step();
        check("bp_idle",        busy,      1'b0);

        // Empty range 10..5.
        do_start(5'd10, 5'd5);
        capture(20);
        check("empty_beats",    beat_idx.size(), 0);
        check("empty_done_cyc", done_cyc, 2);
        check("empty_busy_after", busy_after, 1'b0);

        // Clamped range on the 31-register instance: 30..31 -> one beat at 30.
        first2 = 5'd30;
        last2  = 5'd31;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("clamp_read_novalid", out_valid2, 1'b0);
        step();
        check("clamp_valid",  out_valid2, 1'b1);
        check("clamp_index",  out_index2, 5'd30);
        check("clamp_data",   out_data2,  32'hA01E);
        check("clamp_last",   out_last2,  1'b1);
        step();
        check("clamp_done",   done2,      1'b1);
        check("clamp_novalid", out_valid2, 1'b0);
        step();
        check("clamp_idle",   busy2,      1'b0);

        // Start while busy is ignored.
        out_ready = 1'b0;
        do_start(5'd6, 5'd9);
        step();
        check("sb_in_send", out_valid, 1'b1);
        first_idx = 5'd0;
        last_idx  = 5'd1;
        start     = 1'b1;
        step();
        start     = 1'b0;
        check("sb_index_held", out_index, 5'd6);
        out_ready = 1'b1;
        capture(100);
        check("sb_beats", beat_idx.size(), 4);
        if (beat_idx.size() == 4) begin
            check("sb_idx0", beat_idx[0], 6);
            check("sb_idx3", beat_idx[3], 9);
            check("sb_dat3", beat_dat[3], 32'h20);
            check("sb_last3", beat_last[3], 1'b1);
        end
        check("sb_busy_after", busy_after, 1'b0);

        // Reset during the third beat of 0..31.
        do_start(5'd0, 5'd31);
        for (int k = 0; k < 5; k++) step();
        check("mr_third_valid", out_valid, 1'b1);
        check("mr_third_index", out_index, 5'd2);
        #2 rst = 1'b0;
        #1;
        check("mr_valid_drop", out_valid,  1'b0);
        check("mr_busy_drop",  busy,       1'b0);
        check("mr_stall_drop", core_stall, 1'b0);
        check("mr_done_low",   done,       1'b0);
        step();
        check("mr_held_valid", out_valid, 1'b0);
        check("mr_held_done",  done,      1'b0);
        #3 rst = 1'b1;
        step();
        check("mr_idle_after", busy, 1'b0);
        do_start(5'd20, 5'd21);
        capture(50);
        check("mr_beats", beat_idx.size(), 2);
        if (beat_idx.size() == 2) begin
            check("mr_idx0", beat_idx[0], 20);
            check("mr_dat0", beat_dat[0], rf[20]);
            check("mr_idx1", beat_idx[1], 21);
            check("mr_dat1", beat_dat[1], rf[21]);
            check("mr_last1", beat_last[1], 1'b1);
        end
        check("mr_done_cyc", done_cyc, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
